alu_md: RTL and testbench

//  Parametrised EX-stage ALU for the MIPS pipeline with an iterative multiply/divide unit and HI/LO registers.

---
 rtl/alu_md.sv | 178 +++++++++++++++++
 tb/tb_alu_md.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// EX-stage ALU with an iterative multiply/divide unit and HI/LO registers.
// Single-cycle ops are combinational; MULT/MULTU/DIV/DIVU iterate one bit per cycle.
module alu_md #(
    parameter int WIDTH  = 32,
    parameter bit EN_DIV = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [7:0]       alu_in,
    input  logic             ex_valid,
    output logic             zero,
    output logic [WIDTH-1:0] alu_out,
    output logic             stall,
    output logic             busy,
    output logic             md_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic [1:0] aluop;
    logic [5:0] funct;
    logic       is_r, f_mult, f_div, f_md, f_hilo, sgn_op, a_neg, b_neg, launch;
    logic signed [WIDTH-1:0] a_s, b_s;

    assign aluop  = alu_in[7:6];
    assign funct  = alu_in[5:0];
    assign a_s    = a;
    assign b_s    = b;
    assign is_r   = (aluop == 2'b10);
    assign f_mult = (funct == F_MULT) || (funct == F_MULTU);
    assign f_div  = EN_DIV && ((funct == F_DIV) || (funct == F_DIVU));
    assign f_md   = f_mult || f_div;
    assign f_hilo = (funct == F_MFHI) || (funct == F_MFLO) || (funct == F_MTHI) || (funct == F_MTLO);
    // funct[0] clear selects the signed flavour of both MULT and DIV
    assign sgn_op = ~funct[0];
    assign a_neg  = sgn_op & a[WIDTH-1];
    assign b_neg  = sgn_op & b[WIDTH-1];

    assign zero   = (a == b);
    assign stall  = ex_valid & is_r & busy & (f_md | f_hilo);
    assign launch = ex_valid & is_r & f_md & ~busy;

    logic [WIDTH-1:0] hi, lo;
    logic [CW-1:0]    cnt;

    always_comb begin
        alu_out = '0;
        case (aluop)
            2'b00: alu_out = a + b;
            2'b01: alu_out = a - b;
            2'b11: alu_out = a | b;
            default: begin
                case (funct)
                    F_ADD:  alu_out = a + b;
                    F_SUB:  alu_out = a - b;
                    F_AND:  alu_out = a & b;
                    F_OR:   alu_out = a | b;
                    F_XOR:  alu_out = a ^ b;
                    F_NOR:  alu_out = ~(a | b);
                    F_SLT:  alu_out = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
                    F_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
                    F_MFHI: alu_out = hi;
                    F_MFLO: alu_out = lo;
                    default: alu_out = '0;
                endcase
            end
        endcase
    end

    // Iteration state: acc_p0 holds {partial product, multiplier} or {remainder, quotient}
    logic [2*WIDTH:0] acc_p0, acc_nxt;
    logic [WIDTH-1:0] opnd_p0, a_orig_p0;
    logic             op_div_p0, neg_q_p0, neg_r_p0, div_zero_p0;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic             div_ge;

    always_comb begin
        mul_sum   = acc_p0[2*WIDTH:WIDTH] + (acc_p0[0] ? {1'b0, opnd_p0} : '0);
        div_shift = {acc_p0[2*WIDTH-1:WIDTH], acc_p0[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_p0};
        div_ge    = (div_shift >= {1'b0, opnd_p0});
        if (op_div_p0)
            acc_nxt = {(div_ge ? div_trial : div_shift), acc_p0[WIDTH-2:0], div_ge};
        else
            acc_nxt = {1'b0, mul_sum, acc_p0[WIDTH-1:1]};
    end

    // min_int / -1 needs no special case: |min_int| divides to min_int with matching signs
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    always_comb begin
        prod   = cond_neg2(acc_nxt[2*WIDTH-1:0], neg_q_p0);
        fin_hi = prod[2*WIDTH-1:WIDTH];
        fin_lo = prod[WIDTH-1:0];
        if (op_div_p0) begin
            if (div_zero_p0) begin
                fin_lo = '1;
                fin_hi = a_orig_p0;
            end else begin
                fin_lo = cond_neg(acc_nxt[WIDTH-1:0], neg_q_p0);
                fin_hi = cond_neg(acc_nxt[2*WIDTH-1:WIDTH], neg_r_p0);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= 1'b0;
            md_done <= 1'b0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            md_done <= 1'b0;
            if (busy) begin
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    busy    <= 1'b0;
                    md_done <= 1'b1;
                    cnt     <= '0;
                    hi      <= fin_hi;
                    lo      <= fin_lo;
                end
            end else if (launch) begin
                busy <= 1'b1;
                cnt  <= '0;
            end else if (ex_valid && is_r && funct == F_MTHI) begin
                hi <= a;
            end else if (ex_valid && is_r && funct == F_MTLO) begin
                lo <= a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (launch) begin
            acc_p0      <= {{(WIDTH+1){1'b0}}, cond_neg(a, a_neg)};
            opnd_p0     <= cond_neg(b, b_neg);
            a_orig_p0   <= a;
            op_div_p0   <= f_div;
            neg_q_p0    <= a_neg ^ b_neg;
            neg_r_p0    <= a_neg;
            div_zero_p0 <= f_div & (b == '0);
        end else if (busy) begin
            acc_p0 <= acc_nxt;
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Bench for alu_md: table-driven single-cycle ops plus scoreboarded multiply/divide sequences.
module tb_alu_md;

    localparam int W = 32;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a, b;
    logic [7:0]   alu_in;
    logic         ex_valid;
    logic         zero, stall, busy, md_done;
    logic [W-1:0] alu_out;

    alu_md #(.WIDTH(W), .EN_DIV(1'b1)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .alu_in(alu_in), .ex_valid(ex_valid),
        .zero(zero), .alu_out(alu_out), .stall(stall), .busy(busy), .md_done(md_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]   op;
        logic [5:0]   fn;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W-1:0] y;
        logic         z;
    } vec_t;

    typedef struct {
        string       nm;
        logic [63:0] hl;
    } exp_t;

    vec_t tbl[18];
    exp_t sb[$];

    task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: event did not occur, required it", nm);
    endtask

    function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
        logic signed [63:0] sa, sbv;
        logic signed [31:0] qa, qb, q, r;
        sa  = {{32{av[31]}}, av};
        sbv = {{32{bv[31]}}, bv};
        qa  = av;
        qb  = bv;
        case (f)
            F_MULT:  return sa * sbv;
            F_MULTU: return {32'b0, av} * {32'b0, bv};
            F_DIV: begin
                if (bv == 32'h0) return {av, 32'hFFFF_FFFF};
                if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = qa / qb;
                r = qa % qb;
                return {r, q};
            end
            default: begin
                if (bv == 32'h0) return {av, 32'hFFFF_FFFF};
                return {av % bv, av / bv};
            end
        endcase
    endfunction

    task automatic idle();
        ex_valid = 1'b0;
        alu_in   = {2'b10, F_ADD};
    endtask

    task automatic drive_md(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                            input logic [63:0] e, input string nm);
        exp_t x;
        ex_valid = 1'b1;
        alu_in   = {2'b10, f};
        a        = av;
        b        = bv;
        x.nm     = nm;
        x.hl     = e;
        sb.push_back(x);
    endtask

    task automatic launch(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] e, input string nm);
        @(negedge clk);
        drive_md(f, av, bv, e, nm);
        #1;
        chkb({nm, " launch stall"}, stall, 1'b0);
        chkw({nm, " launch alu_out"}, 64'(alu_out), 64'h0);
        @(posedge clk);
        #1;
        idle();
    endtask

    // Waits for md_done, counting busy/stall cycles on the way, then checks HI/LO in the done cycle.
    task automatic wait_done(output int bcnt, output int scnt);
        logic [7:0]   s_in;
        logic [W-1:0] hv, lv;
        logic         seen;
        exp_t         e;
        bcnt = 0;
        scnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 3 * W && !seen; i++) begin
            @(negedge clk);
            if (md_done) seen = 1'b1;
            else begin
                if (busy)  bcnt++;
                if (stall) scnt++;
            end
        end
        if (!seen) begin
            fail_now("md_done timeout");
            return;
        end
        chkb("stall in done cycle", stall, 1'b0);
        if (sb.size() == 0) begin
            fail_now("scoreboard entry");
            return;
        end
        e      = sb.pop_front();
        s_in   = alu_in;
        alu_in = {2'b10, F_MFHI};
        #1 hv  = alu_out;
        alu_in = {2'b10, F_MFLO};
        #1 lv  = alu_out;
        chkw({e.nm, " HI:LO"}, {hv, lv}, e.hl);
        alu_in = s_in;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          bc, sc, pulses;
    logic [63:0] e64;

    initial begin
        tbl[0]  = '{2'b00, 6'h00,  32'h0000_000F, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0};
        tbl[1]  = '{2'b01, 6'h00,  32'h0000_000F, 32'hFFFF_FFF0, 32'h0000_001F, 1'b0};
        tbl[2]  = '{2'b11, 6'h00,  32'h0000_000F, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0};
        tbl[3]  = '{2'b10, F_ADD,  32'h0000_000F, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0};
        tbl[4]  = '{2'b10, F_SUB,  32'h0000_000F, 32'hFFFF_FFF0, 32'h0000_001F, 1'b0};
        tbl[5]  = '{2'b10, F_AND,  32'h0000_000F, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0};
        tbl[6]  = '{2'b10, F_OR,   32'h0000_000F, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0};
        tbl[7]  = '{2'b10, F_XOR,  32'h0000_000F, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0};
        tbl[8]  = '{2'b10, F_NOR,  32'h0000_000F, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0};
        tbl[9]  = '{2'b10, F_SLT,  32'h0000_000F, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0};
        tbl[10] = '{2'b10, F_SLTU, 32'h0000_000F, 32'hFFFF_FFF0, 32'h0000_0001, 1'b0};
        tbl[11] = '{2'b10, 6'h3F,  32'h0000_000F, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0};
        tbl[12] = '{2'b10, F_SUB,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1};
        tbl[13] = '{2'b10, F_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
        tbl[14] = '{2'b10, F_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        tbl[15] = '{2'b10, F_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
        tbl[16] = '{2'b00, 6'h00,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        tbl[17] = '{2'b01, 6'h00,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};

        reset = 1'b1; ex_valid = 1'b0; alu_in = 8'h0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chkb("reset busy", busy, 1'b0);
        chkb("reset md_done", md_done, 1'b0);
        chkb("reset stall", stall, 1'b0);
        alu_in = {2'b10, F_MFHI};
        #1 chkw("reset HI", 64'(alu_out), 64'h0);
        alu_in = {2'b10, F_MFLO};
        #1 chkw("reset LO", 64'(alu_out), 64'h0);
        reset = 1'b0;
        idle();

        // single-cycle ops
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            ex_valid = 1'b1;
            alu_in   = {tbl[i].op, tbl[i].fn};
            a        = tbl[i].av;
            b        = tbl[i].bv;
            #1;
            chkw($sformatf("alu vec %0d", i), 64'(alu_out), 64'(tbl[i].y));
            chkb($sformatf("zero vec %0d", i), zero, tbl[i].z);
        end
        idle();

        // a bubble carrying an MD funct must not launch
        @(negedge clk);
        ex_valid = 1'b0; alu_in = {2'b10, F_MULT}; a = 32'd3; b = 32'd3;
        @(posedge clk);
        #1 chkb("bubble no launch", busy, 1'b0);
        idle();

        // multiply
        launch(F_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, "MULT -3*7");
        wait_done(bc, sc);
        chkw("MULT busy cycles", 64'(bc), 64'(W));
        @(negedge clk);
        chkb("md_done one cycle", md_done, 1'b0);
        launch(F_MULTU, 32'hFFFF_FFFD, 32'd7, 64'h0000_0006_FFFF_FFEB, "MULTU");
        wait_done(bc, sc);
        launch(F_MULT, 32'h8000_0000, 32'h8000_0000, md_model(F_MULT, 32'h8000_0000, 32'h8000_0000), "MULT min*min");
        wait_done(bc, sc);
        launch(F_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, md_model(F_MULTU, 32'hDEAD_BEEF, 32'h1234_5678), "MULTU big");
        wait_done(bc, sc);

        // divide
        launch(F_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, "DIV -7/2");
        wait_done(bc, sc);
        chkw("DIV busy cycles", 64'(bc), 64'(W));
        launch(F_DIV, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, "DIV 5/0");
        wait_done(bc, sc);
        chkw("DIV0 busy cycles", 64'(bc), 64'(W));
        launch(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "DIV min/-1");
        wait_done(bc, sc);
        launch(F_DIV, 32'd100, 32'hFFFF_FFF9, md_model(F_DIV, 32'd100, 32'hFFFF_FFF9), "DIV 100/-7");
        wait_done(bc, sc);
        launch(F_DIVU, 32'hFFFF_FFF9, 32'd10, md_model(F_DIVU, 32'hFFFF_FFF9, 32'd10), "DIVU big/10");
        wait_done(bc, sc);
        launch(F_DIVU, 32'h8000_0001, 32'd0, md_model(F_DIVU, 32'h8000_0001, 32'd0), "DIVU x/0");
        wait_done(bc, sc);

        // stall behaviour: non-MD op overlaps, MFLO waits for the result
        e64 = md_model(F_MULT, 32'd1234, 32'hFFFF_FFC8);
        launch(F_MULT, 32'd1234, 32'hFFFF_FFC8, e64, "MULT stall");
        @(negedge clk);
        ex_valid = 1'b1; alu_in = {2'b10, F_ADD}; a = 32'd100; b = 32'd23;
        #1;
        chkb("ADD during busy stall", stall, 1'b0);
        chkw("ADD during busy sum", 64'(alu_out), 64'd123);
        chkb("busy during overlap", busy, 1'b1);
        alu_in = {2'b10, F_MFLO};
        #1 chkb("MFLO stalled", stall, 1'b1);
        wait_done(bc, sc);
        chkw("MFLO stall cycles", 64'(sc), 64'(W - 1));
        #1 chkw("MFLO result", 64'(alu_out), 64'(e64[31:0]));
        idle();

        // back-to-back: DIVU issued in the md_done cycle of a MULTU
        launch(F_MULTU, 32'h0001_2345, 32'h000A_BCDE, md_model(F_MULTU, 32'h0001_2345, 32'h000A_BCDE), "MULTU b2b");
        wait_done(bc, sc);
        drive_md(F_DIVU, 32'd1000003, 32'd17, md_model(F_DIVU, 32'd1000003, 32'd17), "DIVU b2b");
        #1 chkb("b2b launch stall", stall, 1'b0);
        @(posedge clk);
        #1 chkb("b2b second launch", busy, 1'b1);
        idle();
        @(negedge clk);
        ex_valid = 1'b1; alu_in = {2'b10, F_MTHI}; a = 32'hCAFE_F00D;
        #1 chkb("MTHI stalled", stall, 1'b1);
        wait_done(bc, sc);
        chkw("MTHI stall cycles", 64'(sc), 64'(W - 1));
        @(posedge clk);
        #1 idle();
        alu_in = {2'b10, F_MFHI};
        #1 chkw("MTHI landed", 64'(alu_out), 64'hCAFE_F00D);
        @(negedge clk);
        ex_valid = 1'b1; alu_in = {2'b10, F_MTLO}; a = 32'h0000_55AA;
        #1 chkb("MTLO idle stall", stall, 1'b0);
        @(posedge clk);
        #1 idle();
        alu_in = {2'b10, F_MFLO};
        #1 chkw("MTLO landed", 64'(alu_out), 64'h55AA);
        idle();

        // reset in the middle of an iteration
        launch(F_MULT, 32'h0000_FFFF, 32'h0000_FFFF, md_model(F_MULT, 32'h0000_FFFF, 32'h0000_FFFF), "MULT aborted");
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chkb("abort busy", busy, 1'b0);
        chkb("abort md_done", md_done, 1'b0);
        alu_in = {2'b10, F_MFHI};
        #1 chkw("abort HI", 64'(alu_out), 64'h0);
        alu_in = {2'b10, F_MFLO};
        #1 chkw("abort LO", 64'(alu_out), 64'h0);
        sb.delete();
        idle();
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (md_done || busy) pulses++;
        end
        chkw("no md_done after abort", 64'(pulses), 64'h0);
        launch(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, md_model(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), "MULTU after reset");
        wait_done(bc, sc);
        chkw("post-reset busy cycles", 64'(bc), 64'(W));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
